// File: rtl/ft245_pkg.sv
// rtl/ft245_pkg.sv - shared handshake state types and timing constants for the FT245 slave bridge
package ft245_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ACTIVE,
    RD_PRECHARGE
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HIGH,
    WR_PRECHARGE
  } wr_state_t;

  // Cycles the ready strobe (nRXF / nTXE) is held inactive after each transfer
  localparam int PRECHARGE_CYCLES = 1;
  localparam int PRE_CNT_W        = 4;

endpackage

// File: rtl/sync_byte_fifo.sv
// rtl/sync_byte_fifo.sv - single-clock byte FIFO with first-word-fall-through head
module sync_byte_fifo #(
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          push_ok,
  output logic          pop_ok
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty; subtraction wraps naturally
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A pop on empty is ignored; a push on full only lands if a pop frees the slot this cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the contents by collapsing both pointers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ft245_slave_bridge.sv
// rtl/ft245_slave_bridge.sv - FT245BM slave-side emulation between a host byte stream and the JTAG shifter
module ft245_slave_bridge
  import ft245_pkg::*;
#(
  parameter int RX_AW = 4,
  parameter int TX_AW = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       nRXF,
  output logic       nTXE,
  input  logic       nRD,
  input  logic       WR,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic       RD_UNDERRUN,
  output logic       WR_OVERRUN
);

  localparam logic [RX_AW:0]     RX_LAST = (RX_AW+1)'((1 << RX_AW) - 1);
  localparam logic [TX_AW:0]     TX_ONE  = (TX_AW+1)'(1);
  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRECHARGE_CYCLES - 1);

  rd_state_t rd_state;
  wr_state_t wr_state;
  logic      nrd_q;
  logic      wr_q;
  logic [PRE_CNT_W-1:0] rd_pre_cnt;
  logic [PRE_CNT_W-1:0] wr_pre_cnt;

  logic [7:0]     rx_head, tx_head;
  logic [RX_AW:0] rx_count;
  logic [TX_AW:0] tx_count;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push_ok, rx_pop_ok, tx_push_ok, tx_pop_ok;
  logic rx_push, tx_pop, rd_rise, wr_fall;
  logic rx_full_nxt, tx_empty_nxt;

  assign rx_push = RX_VALID && RX_READY;
  assign tx_pop  = TX_VALID && TX_READY;
  assign rd_rise = (rd_state == RD_ACTIVE) && !nrd_q && nRD;
  assign wr_fall = (wr_state == WR_HIGH) && wr_q && !WR;

  sync_byte_fifo #(.AW(RX_AW)) u_rx_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (rx_push),
    .push_data (RX_DATA),
    .pop       (rd_rise),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .push_ok   (rx_push_ok),
    .pop_ok    (rx_pop_ok)
  );

  sync_byte_fifo #(.AW(TX_AW)) u_tx_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (wr_fall),
    .push_data (D_IN),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty),
    .push_ok   (tx_push_ok),
    .pop_ok    (tx_pop_ok)
  );

  // Post-edge occupancy, so the host-side flags never lag the FIFO they guard
  assign rx_full_nxt  = rx_full ? !(rx_pop_ok && !rx_push_ok)
                                : (rx_push_ok && !rx_pop_ok && (rx_count == RX_LAST));
  assign tx_empty_nxt = tx_empty ? !tx_push_ok
                                 : (tx_pop_ok && !tx_push_ok && (tx_count == TX_ONE));

  // Bus is driven only while the shifter holds nRD low, and never during reset
  assign D_OE    = nRST && !nRD;
  assign D_OUT   = rx_empty ? 8'h00 : rx_head;
  assign TX_DATA = tx_head;

  // Host-side flow-control flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      RX_READY <= 1'b0;
      TX_VALID <= 1'b0;
    end else begin
      RX_READY <= !rx_full_nxt;
      TX_VALID <= !tx_empty_nxt;
    end
  end

  // Read handshake: present the RX head while nRD is low, pop on its release
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_state    <= RD_IDLE;
      nRXF        <= 1'b1;
      nrd_q       <= 1'b1;
      rd_pre_cnt  <= '0;
      RD_UNDERRUN <= 1'b0;
    end else begin
      nrd_q <= nRD;
      case (rd_state)
        RD_IDLE: begin
          nRXF <= rx_empty;
          if (!nRD) rd_state <= RD_ACTIVE;
        end
        RD_ACTIVE: begin
          if (rd_rise) begin
            nRXF       <= 1'b1;
            rd_pre_cnt <= '0;
            rd_state   <= RD_PRECHARGE;
            if (!rx_pop_ok) RD_UNDERRUN <= 1'b1;
          end
        end
        RD_PRECHARGE: begin
          if (rd_pre_cnt == PRE_LAST) begin
            nRXF     <= rx_empty;
            rd_state <= RD_IDLE;
          end else begin
            rd_pre_cnt <= rd_pre_cnt + 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write handshake: arm on WR high, capture D_IN on its falling edge
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_state   <= WR_IDLE;
      nTXE       <= 1'b1;
      wr_q       <= 1'b0;
      wr_pre_cnt <= '0;
      WR_OVERRUN <= 1'b0;
    end else begin
      wr_q <= WR;
      case (wr_state)
        WR_IDLE: begin
          nTXE <= tx_full;
          if (WR) wr_state <= WR_HIGH;
        end
        WR_HIGH: begin
          if (wr_fall) begin
            nTXE       <= 1'b1;
            wr_pre_cnt <= '0;
            wr_state   <= WR_PRECHARGE;
            if (!tx_push_ok) WR_OVERRUN <= 1'b1;
          end
        end
        WR_PRECHARGE: begin
          if (wr_pre_cnt == PRE_LAST) begin
            nTXE     <= tx_full;
            wr_state <= WR_IDLE;
          end else begin
            wr_pre_cnt <= wr_pre_cnt + 1'b1;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule
